// File: rtl/onehot_decoder_pipe.sv
// onehot_decoder_pipe
//   Registered binary-to-one-hot decoder with valid/ready handshaking on both
//   sides. The output register holds one word. A new word may replace the
//   current one in the same cycle it is consumed, so the block sustains one
//   word per cycle.
//
//   Optional scan mode (compile with `define ONEHOT_DECODER_SCAN_EN):
//   a one-cycle scan_start pulse walks every output line from index 0 up to
//   2**IN_W-1. SCAN_DWELL idle cycles are inserted between beats. The scan
//   never wraps. Without the macro, scan_start is ignored and busy is 0.
//
// Parameters
//   IN_W        binary input width (1..6); output width is 2**IN_W
//   SCAN_DWELL  idle cycles between scan beats (0 = back-to-back)
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   in_valid     input_bits valid
//   in_ready     block can accept input_bits this cycle
//   input_bits   binary index to decode
//   scan_start   one-cycle scan request (scan build only)
//   out_valid    output_bits holds a decoded word
//   out_ready    consumer accepts the word this cycle
//   output_bits  one-hot word, all-zero whenever out_valid is low
//   out_index    binary index of the presented word
//   busy         scan sequence in progress
module onehot_decoder_pipe #(
  parameter int IN_W       = 4,
  parameter int SCAN_DWELL = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       input_bits,
  input  logic                  scan_start,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [(1<<IN_W)-1:0]  output_bits,
  output logic [IN_W-1:0]       out_index,
  output logic                  busy
);

  localparam int OUT_W = 1 << IN_W;

  function automatic logic [OUT_W-1:0] to_onehot(input logic [IN_W-1:0] idx);
    logic [OUT_W-1:0] word;
    word      = '0;
    word[idx] = 1'b1;
    return word;
  endfunction

  logic accept;
  logic handshake;

  assign handshake = out_valid && out_ready;

`ifdef ONEHOT_DECODER_SCAN_EN

  localparam int CNT_W = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'((SCAN_DWELL > 0) ? SCAN_DWELL - 1 : 0);
  localparam logic [IN_W-1:0]  TOP_IDX    = '1;

  typedef enum logic [1:0] {IDLE, SCAN, GAP} state_t;

  state_t           state;
  logic [CNT_W-1:0] dwell_cnt;
  logic [IN_W-1:0]  next_idx;

  assign next_idx = out_index + IN_W'(1);

  // scan_start wins over in_valid, so it masks in_ready in the same cycle.
  assign in_ready = !rst && (state == IDLE) && (!out_valid || out_ready) && !scan_start;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      output_bits <= '0;
      out_index   <= '0;
      busy        <= 1'b0;
      dwell_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (scan_start) begin
            // Any pending direct word is dropped in favour of the scan.
            state       <= SCAN;
            busy        <= 1'b1;
            out_valid   <= 1'b1;
            out_index   <= '0;
            output_bits <= to_onehot('0);
          end else if (accept) begin
            out_valid   <= 1'b1;
            out_index   <= input_bits;
            output_bits <= to_onehot(input_bits);
          end else if (handshake) begin
            out_valid   <= 1'b0;
            output_bits <= '0;
          end
        end
        SCAN: begin
          if (handshake) begin
            if (out_index == TOP_IDX) begin
              state       <= IDLE;
              busy        <= 1'b0;
              out_valid   <= 1'b0;
              output_bits <= '0;
            end else if (SCAN_DWELL == 0) begin
              out_index   <= next_idx;
              output_bits <= to_onehot(next_idx);
            end else begin
              // out_index keeps the last beat so GAP knows where to resume.
              state       <= GAP;
              out_valid   <= 1'b0;
              output_bits <= '0;
              dwell_cnt   <= '0;
            end
          end
        end
        GAP: begin
          if (dwell_cnt == DWELL_LAST) begin
            state       <= SCAN;
            out_valid   <= 1'b1;
            out_index   <= next_idx;
            output_bits <= to_onehot(next_idx);
          end else begin
            dwell_cnt <= dwell_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`else

  logic unused_cfg;

  assign unused_cfg = ^{scan_start, 32'(SCAN_DWELL)};
  assign busy       = 1'b0;
  assign in_ready   = !rst && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      output_bits <= '0;
      out_index   <= '0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_index   <= input_bits;
      output_bits <= to_onehot(input_bits);
    end else if (handshake) begin
      out_valid   <= 1'b0;
      output_bits <= '0;
    end
  end

`endif

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// tb_onehot_decoder_pipe
//   Scoreboard bench for onehot_decoder_pipe with default parameters.
//   Accepted inputs (and scan sequences) push expected indices; every output
//   handshake pops one and compares the word and index. Scan-mode sections
//   are built only when ONEHOT_DECODER_SCAN_EN is defined.
module tb_onehot_decoder_pipe;

  localparam int IN_W       = 4;
  localparam int OUT_W      = 1 << IN_W;
  localparam int SCAN_DWELL = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  input_bits;
  logic             scan_start;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] output_bits;
  logic [IN_W-1:0]  out_index;
  logic             busy;

  int vectors     = 0;
  int miscompares = 0;
  logic [IN_W-1:0] exp_q[$];
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  onehot_decoder_pipe #(.IN_W(IN_W), .SCAN_DWELL(SCAN_DWELL)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .input_bits  (input_bits),
    .scan_start  (scan_start),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .output_bits (output_bits),
    .out_index   (out_index),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop on handshake, push on accept, both sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (!out_valid) check("zero_when_invalid", output_bits, '0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", out_valid, 1'b0);
        end else begin
          logic [IN_W-1:0] e;
          e = exp_q.pop_front();
          check("word_bits", output_bits, 64'(1) << e);
          check("word_index", out_index, e);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(input_bits);
    end
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    input_bits = '0;
    scan_start = 1'b0;
    out_ready  = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_output_bits", output_bits, '0);
    check("rst_out_index", out_index, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    rst    = 1'b0;
    mon_en = 1'b1;
    tick();

    // Single decode of 9.
    in_valid = 1'b1; input_bits = 4'd9; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("dec9_valid", out_valid, 1'b1);
    check("dec9_bits", output_bits, 16'h0200);
    check("dec9_index", out_index, 4'd9);
    tick();
    check("dec9_drained", out_valid, 1'b0);

    // Back-to-back 0, 5, 15 with no bubbles.
    in_valid = 1'b1; input_bits = 4'd0;
    tick();
    check("b2b_0", output_bits, 16'h0001);
    input_bits = 4'd5;
    tick();
    check("b2b_5", output_bits, 16'h0020);
    input_bits = 4'd15;
    tick();
    check("b2b_15", output_bits, 16'h8000);
    in_valid = 1'b0;
    tick();

    // Stall: 3 held for 4 cycles while 7 waits.
    in_valid = 1'b1; input_bits = 4'd3; out_ready = 1'b0;
    tick();
    input_bits = 4'd7;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_bits", output_bits, 16'h0008);
      check("stall_index", out_index, 4'd3);
      check("stall_in_ready", in_ready, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("unstall_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check("unstall_bits", output_bits, 16'h0080);
    tick();

`ifdef ONEHOT_DECODER_SCAN_EN
    begin
      int beats = 0;
      int first = -1;
      int prev  = -1;
      int cyc   = 0;
      int n     = 0;

      // scan_start together with in_valid: scan wins, input refused.
      scan_start = 1'b1; in_valid = 1'b1; input_bits = 4'd11; out_ready = 1'b1;
      #1;
      check("scan_vs_in_ready", in_ready, 1'b0);
      for (int k = 0; k < OUT_W; k++) exp_q.push_back(IN_W'(k));
      tick();
      scan_start = 1'b0; in_valid = 1'b0;
      check("scan_first_busy", busy, 1'b1);
      check("scan_first_valid", out_valid, 1'b1);
      check("scan_first_index", out_index, '0);

      while (busy && cyc < 300) begin
        @(negedge clk);
        if (out_valid) begin
          if (prev >= 0) check("scan_spacing", 32'(cyc - prev), 32'(SCAN_DWELL + 1));
          if (first < 0) first = cyc;
          prev = cyc;
          beats++;
        end
        tick();
        cyc++;
        // Mid-scan restart attempt and input must both be ignored.
        scan_start = (cyc == 10);
        in_valid   = (cyc == 10);
        input_bits = 4'd1;
      end
      scan_start = 1'b0; in_valid = 1'b0;
      check("scan_beats", 32'(beats), 32'(OUT_W));
      check("scan_span", 32'(prev - first), 32'((OUT_W - 1) * (SCAN_DWELL + 1)));
      check("scan_end_busy", busy, 1'b0);
      check("scan_end_valid", out_valid, 1'b0);
      tick();

      // Reset while index 6 is presented.
      scan_start = 1'b1;
      for (int k = 0; k < OUT_W; k++) exp_q.push_back(IN_W'(k));
      tick();
      scan_start = 1'b0;
      while (!(out_valid && out_index == 4'd6) && n < 200) begin
        tick();
        n++;
      end
      check("scan_reach6", out_index, 4'd6);
      rst = 1'b1;
      exp_q.delete();
      tick();
      check("midrst_valid", out_valid, 1'b0);
      check("midrst_bits", output_bits, '0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_in_ready", in_ready, 1'b0);
      rst = 1'b0;
      tick();
      in_valid = 1'b1; input_bits = 4'd2;
      tick();
      in_valid = 1'b0;
      check("postrst_bits", output_bits, 16'h0004);
      tick();
    end
`else
    // Without scan mode, scan_start has no effect on the direct path.
    scan_start = 1'b1; in_valid = 1'b1; input_bits = 4'd4; out_ready = 1'b1;
    #1;
    check("noscan_in_ready", in_ready, 1'b1);
    tick();
    scan_start = 1'b0; in_valid = 1'b0;
    check("noscan_busy", busy, 1'b0);
    check("noscan_bits", output_bits, 16'h0010);
    tick();
`endif

    // Random traffic with random back-pressure.
    for (int i = 0; i < 60; i++) begin
      in_valid   = 1'($urandom_range(0, 1));
      input_bits = IN_W'($urandom_range(0, OUT_W - 1));
      out_ready  = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_idle", out_valid, 1'b0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/onehot_decoder_pipe.md
# onehot_decoder_pipe

Parametrised, registered binary-to-one-hot decoder with valid/ready handshaking on both sides and an optional self-running scan mode that walks every output line in turn. It is the next-generation replacement for the fixed 4-to-16 combinational decoder. It sits between a command/address source and select-line consumers such as bank or chip-select fan-out and LED/matrix drivers. A consumer that needs back-pressure or a lamp-test sequence uses this block instead of the combinational part.

## Interface
- IN_W, default 4: width of the binary input; output width is 2**IN_W (legal range 1..6).
- SCAN_DWELL, default 2: idle cycles inserted between consecutive scan beats (0 = back-to-back).
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input_bits is valid this cycle.
- in_ready  out  1  block can accept input_bits this cycle.
- input_bits  in  IN_W  binary index to decode.
- scan_start  in  1  one-cycle request to start a scan sequence.
- out_valid  out  1  output_bits holds a decoded word.
- out_ready  in  1  consumer accepts the word this cycle.
- output_bits  out  2**IN_W  one-hot word; bit k set for index k.
- out_index  out  IN_W  binary index of the word currently on output_bits.
- busy  out  1  scan sequence in progress.

## Operation
- FSM states: IDLE, SCAN, GAP.
- Reset: state=IDLE; out_valid=0, output_bits=0, out_index=0, busy=0, in_ready=0 while rst is high.
- Output register holds one word. in_ready = (state==IDLE) && (!out_valid || out_ready) && !scan_start.
- Direct accept (IDLE, in_valid && in_ready): next cycle out_valid=1, output_bits=1<<input_bits, out_index=input_bits.
- Consumer handshake (out_valid && out_ready) without a new accept: next cycle out_valid=0, output_bits=0. output_bits is all-zero whenever out_valid=0.
- Simultaneous handshake and accept: the new word replaces the old one with no bubble, giving full throughput of 1 word/cycle.
- Stall (out_valid && !out_ready): output_bits and out_index are held stable; in_ready=0.
- scan_start in IDLE: takes priority over in_valid, so in_valid is not accepted that cycle. Any pending output word is dropped (out_valid deasserts). Next cycle: state=SCAN, busy=1, out_valid=1, index 0.
- SCAN: presents index i. When the handshake completes:
  - i == 2**IN_W-1: go to IDLE, busy=0, out_valid=0.
  - SCAN_DWELL==0: next cycle presents i+1.
  - otherwise: go to GAP with out_valid=0.
- GAP: counts SCAN_DWELL cycles, then returns to SCAN presenting i+1.
- The scan index never wraps; a scan always ends after the top index.
- scan_start and in_valid are ignored while busy=1; in_ready=0 throughout the scan.
- Reset mid-scan: the block returns to IDLE at the reset edge with all outputs at reset values. No partial sequence resumes.

## Timing
- Direct latency: 1 cycle from accept edge to out_valid.
- Scan start: 1 cycle from the scan_start edge to the index-0 beat.
- Scan duration with no back-pressure: 2**IN_W beats + (2**IN_W-1)*SCAN_DWELL gap cycles. With defaults: 16 + 30 = 46 cycles from the first beat to the last handshake.
- No combinational path from input_bits to output_bits. in_ready depends combinationally on out_ready, state and scan_start only.

## Configuration
- ONEHOT_DECODER_SCAN_EN defined: scan mode (SCAN/GAP states, dwell counter, busy) is compiled in as described above.
- Undefined: FSM is IDLE only. scan_start is ignored and busy is tied to 0. in_ready = !out_valid || out_ready, with no scan_start term. Direct path behaviour and timing are otherwise identical.

## Test plan
- Reset, then in_valid=1, input_bits=4'd9, out_ready=1 -> one cycle later out_valid=1, output_bits=16'h0200, out_index=9.
- Back-to-back inputs 0,5,15 with out_ready=1 -> outputs 16'h0001, 16'h0020, 16'h8000 on consecutive cycles, no bubbles.
- Input 3 accepted, out_ready=0 for 4 cycles -> output_bits holds 16'h0008 and in_ready=0 for 4 cycles. The next input is accepted on the cycle out_ready rises.
- (SCAN_EN) scan_start pulse, out_ready=1, SCAN_DWELL=2 -> 16 beats 16'h0001..16'h8000 each separated by 2 idle cycles; busy falls after the last handshake; scan_start pulsed mid-scan is ignored.
- (SCAN_EN) scan_start and in_valid asserted in the same cycle -> scan starts and the input is not accepted (in_ready=0).
- (SCAN_EN) rst asserted while index 6 is presented -> next cycle out_valid=0, output_bits=0, busy=0; after reset release, input 2 decodes to 16'h0004.
